rr_sched: RTL and testbench
===========================

RR_SCHED -- requirements
Module: rr_sched

Interface
REQ-001 Parameter RR_WIDTH, default 4, number of requesters (ports).
REQ-002 Parameter RR_WIDTH_L2, default $clog2(RR_WIDTH), width of binary indices.
REQ-003 Parameter HOLD_MAX, default 1024, maximum grant hold in cycles before forced release; HOLD_W = $clog2(HOLD_MAX+1).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 req_vec  input  RR_WIDTH  per-port request, level-sensitive.
REQ-007 gnt_done  input  1  single-cycle pulse from granted consumer: transfer finished.
REQ-008 gnt_valid  output  1  grant outstanding.
REQ-009 gnt_vec  output  RR_WIDTH  one-hot granted port, zero when gnt_valid=0.
REQ-010 gnt_bin  output  RR_WIDTH_L2  binary index of granted port, held after release.
REQ-011 gnt_abort  output  1  single-cycle pulse: grant force-released by timeout.
REQ-012 prio_out  output  RR_WIDTH_L2  current highest-priority port index.

Function
REQ-013 The block SHALL implement FSM states IDLE and BUSY.
REQ-014 In IDLE with req_vec != 0, the block SHALL select the first requesting port searching upward from prio_out with wrap-around, register it, and enter BUSY; gnt_valid rises the cycle after req is sampled (latency 1).
REQ-015 In IDLE with req_vec == 0, the block SHALL stay in IDLE with gnt_valid=0, gnt_vec=0.
REQ-016 In BUSY, gnt_vec and gnt_bin SHALL remain constant regardless of req_vec changes, including deassertion of the granted request.
REQ-017 gnt_done in BUSY SHALL return FSM to IDLE next cycle, drop gnt_valid, and set prio_out to (gnt_bin+1) mod RR_WIDTH.
REQ-018 gnt_done in IDLE SHALL be ignored.
REQ-019 Consecutive grants SHALL be separated by exactly one IDLE cycle; that IDLE cycle arbitrates using the updated prio_out.
REQ-020 A hold counter SHALL clear on BUSY entry and increment each BUSY cycle; when it reaches HOLD_MAX-1 without gnt_done, the block SHALL pulse gnt_abort for one cycle and release exactly as REQ-017.
REQ-021 gnt_done and timeout in the same cycle SHALL be treated as gnt_done; gnt_abort stays 0.
REQ-022 prio_out SHALL change only on release; wrap from RR_WIDTH-1 to 0.
REQ-023 With a single persistent requester k, the block SHALL regrant k after each one-cycle gap.

Reset
REQ-024 On rstn low, asynchronously: FSM=IDLE, gnt_valid=0, gnt_vec=0, gnt_bin=0, gnt_abort=0, prio_out=0, hold counter=0.
REQ-025 Reset asserted mid-grant SHALL drop the grant without gnt_abort; first post-reset arbitration uses prio_out=0.

Structure
REQ-026 FSM state encoding and default parameter values SHALL live in the shared switch package.
REQ-027 Selection logic SHALL instantiate combinational sub-module rnd_rb_scal (rr_vec_in=req_vec, rr_priority=prio_out); rr_sched adds only registers, FSM, and counter.

Verification
REQ-028 Reset, req_vec=4'b1010, prio_out=0 -> gnt_vec=4'b0010, gnt_bin=1 one cycle later; done -> prio_out=2, next grant gnt_vec=4'b1000.
REQ-029 req_vec=4'b1111 held, done each 3 cycles -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-030 Grant port 3, pulse done -> prio_out wraps to 0; req_vec=4'b1001 -> port 0 granted.
REQ-031 HOLD_MAX=8, grant port 2, no done -> gnt_abort high exactly 8 cycles after gnt_valid rose, prio_out=3; done coincident with timeout -> no abort.
REQ-032 Granted req deasserted while BUSY -> gnt_vec unchanged until done; done while IDLE -> no state change.
REQ-033 rstn low during BUSY -> all outputs zero asynchronously, prio_out=0, no gnt_abort.

Source files
------------

// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin grant scheduler: FSM encoding and defaults.
package rr_sched_pkg;

  localparam int RR_WIDTH_DEF = 4;
  localparam int HOLD_MAX_DEF = 1024;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } rr_state_e;

endpackage

// File: rtl/rr_sched_rnd_rb_scal.sv
// Combinational round-robin selector: first set request at or above the
// priority index, wrapping around to port 0.
module rnd_rb_scal #(
  parameter int RR_WIDTH    = 4,
  parameter int RR_WIDTH_L2 = $clog2(RR_WIDTH)
) (
  input  logic [RR_WIDTH-1:0]    rr_vec_in,
  input  logic [RR_WIDTH_L2-1:0] rr_priority,
  output logic [RR_WIDTH-1:0]    rr_vec_out,
  output logic [RR_WIDTH_L2-1:0] rr_bin_out,
  output logic                   rr_valid
);

  logic [RR_WIDTH_L2-1:0] w_idx;

  // Walk ports starting at the priority index; the first hit wins.
  always_comb begin
    rr_vec_out = '0;
    rr_bin_out = '0;
    rr_valid   = 1'b0;
    w_idx      = '0;
    for (int i = 0; i < RR_WIDTH; i++) begin
      w_idx = RR_WIDTH_L2'((int'(rr_priority) + i) % RR_WIDTH);
      if (!rr_valid && rr_vec_in[w_idx]) begin
        rr_valid          = 1'b1;
        rr_vec_out[w_idx] = 1'b1;
        rr_bin_out        = w_idx;
      end
    end
  end

endmodule

// File: rtl/rr_sched.sv
// Round-robin grant scheduler: registers a selected port, holds it until the
// consumer signals done or the hold timer expires, then rotates priority.
module rr_sched
  import rr_sched_pkg::*;
#(
  parameter int RR_WIDTH    = RR_WIDTH_DEF,
  parameter int RR_WIDTH_L2 = $clog2(RR_WIDTH),
  parameter int HOLD_MAX    = HOLD_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [RR_WIDTH-1:0]    req_vec,
  input  logic                   gnt_done,
  output logic                   gnt_valid,
  output logic [RR_WIDTH-1:0]    gnt_vec,
  output logic [RR_WIDTH_L2-1:0] gnt_bin,
  output logic                   gnt_abort,
  output logic [RR_WIDTH_L2-1:0] prio_out
);

  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  rr_state_e              r_state, w_state_nxt;
  logic [RR_WIDTH-1:0]    r_gnt_vec;
  logic [RR_WIDTH_L2-1:0] r_gnt_bin;
  logic [RR_WIDTH_L2-1:0] r_prio;
  logic [HOLD_W-1:0]      r_hold;
  logic                   r_abort;

  logic [RR_WIDTH-1:0]    w_sel_vec;
  logic [RR_WIDTH_L2-1:0] w_sel_bin;
  logic                   w_sel_valid;
  logic                   w_grant;
  logic                   w_release;
  logic                   w_timeout;
  logic [RR_WIDTH_L2-1:0] w_prio_nxt;

  rnd_rb_scal #(
    .RR_WIDTH    (RR_WIDTH),
    .RR_WIDTH_L2 (RR_WIDTH_L2)
  ) u_sel (
    .rr_vec_in   (req_vec),
    .rr_priority (r_prio),
    .rr_vec_out  (w_sel_vec),
    .rr_bin_out  (w_sel_bin),
    .rr_valid    (w_sel_valid)
  );

  // Priority moves to the port just after the one being released.
  assign w_prio_nxt = (r_gnt_bin == RR_WIDTH_L2'(RR_WIDTH - 1)) ? '0
                                                                : r_gnt_bin + RR_WIDTH_L2'(1);

  // Next-state: grant from IDLE, release on done (which beats timeout) or timer expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_valid) begin
          w_state_nxt = ST_BUSY;
          w_grant     = 1'b1;
        end
      end
      ST_BUSY: begin
        if (gnt_done) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end else if (r_hold == HOLD_W'(HOLD_MAX - 1)) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, grant registers, priority pointer and hold timer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_gnt_vec <= '0;
      r_gnt_bin <= '0;
      r_prio    <= '0;
      r_hold    <= '0;
      r_abort   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_abort <= w_timeout;
      if (w_grant) begin
        r_gnt_vec <= w_sel_vec;
        r_gnt_bin <= w_sel_bin;
        r_hold    <= '0;
      end else if (w_release) begin
        // gnt_bin is deliberately kept so the last winner stays visible.
        r_gnt_vec <= '0;
        r_prio    <= w_prio_nxt;
        r_hold    <= '0;
      end else if (r_state == ST_BUSY) begin
        r_hold <= r_hold + HOLD_W'(1);
      end
    end
  end

  assign gnt_valid = (r_state == ST_BUSY);
  assign gnt_vec   = r_gnt_vec;
  assign gnt_bin   = r_gnt_bin;
  assign gnt_abort = r_abort;
  assign prio_out  = r_prio;

endmodule

// File: tb/tb_rr_sched.sv
// Scoreboard bench for rr_sched: stimulus queues expected grants/aborts,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_rr_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req_vec;
  logic       gnt_done;
  logic       gnt_valid;
  logic [3:0] gnt_vec;
  logic [1:0] gnt_bin;
  logic       gnt_abort;
  logic [1:0] prio_out;

  typedef struct {
    bit is_abort;
    int vec;
    int bin;
    int prio;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  bit   prev_valid = 1'b0;

  rr_sched #(.RR_WIDTH(4), .HOLD_MAX(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_vec   (req_vec),
    .gnt_done  (gnt_done),
    .gnt_valid (gnt_valid),
    .gnt_vec   (gnt_vec),
    .gnt_bin   (gnt_bin),
    .gnt_abort (gnt_abort),
    .prio_out  (prio_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_grant(input int bin, input int prio);
    exp_t e;
    e.is_abort = 1'b0; e.vec = 1 << bin; e.bin = bin; e.prio = prio; e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic push_abort(input int prio);
    exp_t e;
    e.is_abort = 1'b1; e.vec = 0; e.bin = 0; e.prio = prio; e.cyc = cyc + 9;
    q.push_back(e);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the following idle gap.
  task automatic serve(input logic [3:0] req, input int bin, input int prio, input int hold);
    req_vec = req;
    push_grant(bin, prio);
    @(negedge clk);
    repeat (hold - 1) @(negedge clk);
    gnt_done = 1'b1;
    @(negedge clk);
    gnt_done = 1'b0;
    req_vec  = '0;
  endtask

  // Monitor: grant rising edges and abort pulses are matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (gnt_valid && !prev_valid) begin
      chk("grant_queued", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("grant_kind", int'(e.is_abort), 0);
        chk("grant_vec",  int'(gnt_vec),  e.vec);
        chk("grant_bin",  int'(gnt_bin),  e.bin);
        chk("grant_prio", int'(prio_out), e.prio);
        chk("grant_cyc",  cyc,            e.cyc);
      end
    end
    if (gnt_abort) begin
      chk("abort_queued", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("abort_kind", int'(e.is_abort), 1);
        chk("abort_prio", int'(prio_out), e.prio);
        chk("abort_cyc",  cyc,            e.cyc);
      end
    end
    prev_valid = gnt_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; req_vec = '0; gnt_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_vec",   int'(gnt_vec),   0);
    chk("rst_bin",   int'(gnt_bin),   0);
    chk("rst_abort", int'(gnt_abort), 0);
    chk("rst_prio",  int'(prio_out),  0);
    rstn = 1'b1;
    @(negedge clk);

    // 1010 from prio 0 -> port 1, then port 3, then wrap to 0.
    serve(4'b1010, 1, 0, 1);
    chk("p1_prio", int'(prio_out), 2);
    chk("p1_idle", int'(gnt_valid), 0);
    chk("p1_vec0", int'(gnt_vec), 0);
    chk("p1_binheld", int'(gnt_bin), 1);
    serve(4'b1010, 3, 2, 1);
    chk("wrap_prio", int'(prio_out), 0);
    serve(4'b1001, 0, 0, 1);
    serve(4'b1000, 3, 1, 1);

    // All requesting, done every 3 cycles: 0,1,2,3,0 with one idle gap each.
    serve(4'b1111, 0, 0, 3);
    serve(4'b1111, 1, 1, 3);
    serve(4'b1111, 2, 2, 3);
    serve(4'b1111, 3, 3, 3);
    serve(4'b1111, 0, 0, 3);
    chk("all_prio", int'(prio_out), 1);

    // Granted request drops while BUSY; grant must hold until done.
    req_vec = 4'b0100;
    push_grant(2, 1);
    @(negedge clk);
    req_vec = 4'b0000;
    @(negedge clk);
    chk("hold_vec_a", int'(gnt_vec), 4);
    chk("hold_bin_a", int'(gnt_bin), 2);
    req_vec = 4'b0001;
    @(negedge clk);
    chk("hold_vec_b", int'(gnt_vec), 4);
    req_vec = 4'b0000; gnt_done = 1'b1;
    @(negedge clk);
    gnt_done = 1'b0;
    chk("drop_prio", int'(prio_out), 3);
    // Done in IDLE is ignored.
    gnt_done = 1'b1;
    @(negedge clk);
    gnt_done = 1'b0;
    chk("idle_done_valid", int'(gnt_valid), 0);
    chk("idle_done_prio",  int'(prio_out), 3);

    // Single persistent requester is regranted after each gap.
    serve(4'b0010, 1, 3, 2);
    serve(4'b0010, 1, 2, 2);

    // Timeout: port 2 held with no done -> abort 8 cycles after grant.
    req_vec = 4'b0100;
    push_grant(2, 2);
    push_abort(3);
    @(negedge clk);
    req_vec = 4'b0000;
    repeat (8) @(negedge clk);
    chk("to_abort",  int'(gnt_abort), 1);
    chk("to_valid",  int'(gnt_valid), 0);
    chk("to_prio",   int'(prio_out), 3);
    @(negedge clk);
    chk("to_pulse",  int'(gnt_abort), 0);

    // Done coincident with timeout: treated as done, no abort.
    serve(4'b0100, 2, 3, 8);
    chk("co_abort", int'(gnt_abort), 0);
    chk("co_prio",  int'(prio_out), 3);

    // Reset mid-grant: outputs clear asynchronously, priority returns to 0.
    req_vec = 4'b0001;
    push_grant(0, 3);
    @(negedge clk);
    req_vec = 4'b0000;
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", int'(gnt_valid), 0);
    chk("ar_vec",   int'(gnt_vec),   0);
    chk("ar_bin",   int'(gnt_bin),   0);
    chk("ar_abort", int'(gnt_abort), 0);
    chk("ar_prio",  int'(prio_out),  0);
    req_vec = 4'b1100;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    push_grant(2, 0);
    @(negedge clk);
    req_vec = 4'b0000; gnt_done = 1'b1;
    @(negedge clk);
    gnt_done = 1'b0;
    chk("post_rst_prio", int'(prio_out), 3);

    repeat (3) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
